// File: rtl/bayer_line_tap.sv
// Bayer 3-row tap generator: two line stores give each accepted pixel its same-column
// neighbours from the previous two rows, plus column/row indices and CFA phase bits.
module bayer_line_tap #(
    parameter int IMG_W = 128,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vsync,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_p0,
    output logic [DW-1:0] out_p1,
    output logic [DW-1:0] out_p2,
    output logic [6:0]    out_col,
    output logic [9:0]    out_row,
    output logic          out_col_odd,
    output logic          out_row_odd,
    output logic          out_win_ok
);

    localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [6:0]  COL_LAST = 7'(IMG_W - 1);
    localparam logic [9:0]  ROW_MAX  = 10'd1023;

    // Line stores are deliberately not reset; stale rows are masked at the tap outputs.
    logic [DW-1:0] r_la [IMG_W];
    logic [DW-1:0] r_lb [IMG_W];

    logic [6:0]    r_col;
    logic [9:0]    r_row;

    logic [6:0]    w_col;
    logic [9:0]    w_row;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_la_rd;
    logic [DW-1:0] w_lb_rd;

    // A vsync coinciding with a pixel places that pixel at the frame origin.
    always_comb begin
        w_col   = in_vsync ? 7'd0  : r_col;
        w_row   = in_vsync ? 10'd0 : r_row;
        w_addr  = w_col[AW-1:0];
        w_la_rd = r_la[w_addr];
        w_lb_rd = r_lb[w_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_MAX) ? w_row : w_row + 10'd1;
            end else begin
                r_col <= w_col + 7'd1;
                r_row <= w_row;
            end
        end else if (in_vsync) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    // Reads above see pre-write contents, so LB receives the old LA row.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            r_la[w_addr] <= in_data;
            r_lb[w_addr] <= w_la_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_p0     <= '0;
            out_p1     <= '0;
            out_p2     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            out_win_ok <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_p0     <= in_data;
                out_p1     <= (w_row == 10'd0) ? '0 : w_la_rd;
                out_p2     <= (w_row < 10'd2)  ? '0 : w_lb_rd;
                out_col    <= w_col;
                out_row    <= w_row;
                out_win_ok <= (w_row >= 10'd2);
            end
        end
    end

    assign out_col_odd = out_col[0];
    assign out_row_odd = out_row[0];

endmodule

// File: doc/bayer_line_tap.md
BAYER_LINE_TAP -- requirements
Module: bayer_line_tap

Interface
REQ-001 Parameter IMG_W, default 128: active pixels per line; legal range 4..128.
REQ-002 Parameter DW, default 8: pixel width in bits.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 in_vsync  input  1: one-cycle frame-start pulse, synchronous to clk.
REQ-006 in_valid  input  1: in_data carries a Bayer pixel this cycle.
REQ-007 in_data  input  DW: raw Bayer pixel, raster order.
REQ-008 out_valid  output  1: out_* fields carry a valid tap column.
REQ-009 out_p0  output  DW: current-row pixel, which is in_data delayed 1 cycle.
REQ-010 out_p1  output  DW: same column, previous row.
REQ-011 out_p2  output  DW: same column, two rows back.
REQ-012 out_col  output  7: column index of out_p0.
REQ-013 out_row  output  10: row index of out_p0.
REQ-014 out_col_odd / out_row_odd  output  1 each: LSB of out_col / out_row, for CFA phase selection.
REQ-015 out_win_ok  output  1: high when out_row >= 2, meaning all three taps are real image data.

Function
REQ-016 The block SHALL contain two internal line stores, LA (row-1) and LB (row-2), each IMG_W x DW, with 7-bit addresses.
REQ-017 Write column counter col SHALL run 0..IMG_W-1: it increments on each accepted pixel and wraps to 0 after IMG_W-1.
REQ-018 On each col wrap, row SHALL increment; row saturates at 1023.
REQ-019 On an accepted pixel at column c, the block SHALL in the same cycle:
  - read LA[c] and LB[c];
  - write LA[c] <= in_data;
  - write LB[c] <= old LA[c].
  Reads SHALL return pre-write contents (read-before-write).
REQ-020 The taps SHALL be registered with latency 1: the cycle after acceptance, out_valid=1, out_p0=in_data, out_p1=old LA[c], out_p2=old LB[c], out_col=c, out_row=row.
REQ-021 out_p1 SHALL be forced to 0 when row=0; out_p2 SHALL be forced to 0 when row<2, so stale line-store contents are never exposed.
REQ-022 A cycle with in_valid=0 SHALL leave counters and line stores unchanged; next cycle out_valid=0 and all other outputs hold their values.
REQ-023 in_vsync SHALL clear col and row to 0 for the next accepted pixel.
REQ-024 If in_vsync and in_valid are both high in one cycle, the pixel SHALL be accepted as col=0, row=0, and counters then advance to col=1.
REQ-025 A vsync arriving mid-line SHALL abandon the partial line; line-store contents are retained but masked per REQ-021.
REQ-026 Back-to-back pixels at full rate (in_valid high every cycle) SHALL be sustained with no stall and no backpressure.

Reset
REQ-027 While rst is high: all outputs = 0, col = 0, row = 0.
REQ-028 Line-store contents SHALL NOT be reset; correctness relies on REQ-021 masking.
REQ-029 Reset asserted mid-line SHALL abort the frame; after release, the first accepted pixel is col=0, row=0 regardless of vsync.

Verification
REQ-030 IMG_W=8; vsync, then 24 contiguous pixels with value = 16*row + col -> at row 2 col 3: out_p0=0x23, out_p1=0x13, out_p2=0x03, out_win_ok=1.
REQ-031 Same stream -> rows 0 and 1: out_p2=0 and out_win_ok=0; row 0: out_p1=0.
REQ-032 in_valid toggling 1,0,1,0 across a line -> out_valid mirrors in_valid one cycle late; col sequence is contiguous 0..7 with no skips.
REQ-033 vsync asserted at col 5 of row 3 together with a pixel of value 0xAA -> next out_col=0, out_row=0, out_p0=0xAA, out_p1=0.
REQ-034 rst pulsed mid-row 2 and released, then 8 pixels -> outputs are 0 during reset; first output after release has out_row=0, out_col=0, out_p2=0.
REQ-035 IMG_W=128; 1100 lines of 128 pixels -> out_row saturates at 1023; at the wrap from col 127 to col 0, out_col_odd goes 1 to 0.
